// File: rtl/stack_calc_core_if.sv
// Command, RAM and status bundle for stack_calc_core; master = engine side.
// Commands use a valid/ready handshake; RAM port is single-cycle with registered read data.
interface stack_calc_core_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;

  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] top_val;
  logic [ADDR_W:0]   depth;
  logic              empty;
  logic              full;
  logic              err_underflow;
  logic              err_overflow;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, mem_rdata,
    output cmd_ready, mem_cs, mem_we, mem_addr, mem_wdata,
    output top_val, depth, empty, full, err_underflow, err_overflow
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, mem_rdata,
    input  cmd_ready, mem_cs, mem_we, mem_addr, mem_wdata,
    input  top_val, depth, empty, full, err_underflow, err_overflow
  );
endinterface

// File: rtl/stack_calc_core.sv
// Stack calculator over an external sync RAM, TOS cached; STACK_CALC_SAT_EN selects saturating ADD/SUB.
// Latency 1-4 cycles per command (CLEAR: depth+1); cmd_ready only in IDLE, commands offered while busy are ignored.
module stack_calc_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  stack_calc_core_if.master bus
);
  localparam int D = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_MAX = D[ADDR_W:0];
  localparam logic [ADDR_W:0]   DEPTH_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_PUSH  = 3'd1,
    OP_POP   = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_DUP   = 3'd5,
    OP_SWAP  = 3'd6,
    OP_CLEAR = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_CAP,
    S_WR2,
    S_CLR
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [DATA_W-1:0] data;
  } cmd_t;

  state_e            state, state_nxt;
  cmd_t              cmd_q;
  op_e               in_op;
  logic              accept;
  logic [ADDR_W:0]   depth;
  logic [DATA_W-1:0] top_val;
  logic [DATA_W-1:0] tmp_q;
  logic              err_underflow, err_overflow;
  logic              empty_w, full_w, depth_le1;
  logic [ADDR_W-1:0] tos_addr, nos_addr, free_addr;
  logic [DATA_W-1:0] add_res, sub_res, alu_res;
  logic              mem_cs, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign in_op     = op_e'(bus.cmd_op);
  assign accept    = bus.cmd_valid && (state == S_IDLE);
  assign empty_w   = (depth == '0);
  assign full_w    = (depth == DEPTH_MAX);
  assign depth_le1 = (depth <= DEPTH_ONE);

  // Stack grows downward from address D-1, so TOS sits at D-depth.
  assign tos_addr  = ADDR_W'(DEPTH_MAX - depth);
  assign nos_addr  = tos_addr + ADDR_ONE;
  assign free_addr = tos_addr - ADDR_ONE;

`ifdef STACK_CALC_SAT_EN
  logic [DATA_W:0] sum_w;
  assign sum_w   = {1'b0, bus.mem_rdata} + {1'b0, top_val};
  assign add_res = sum_w[DATA_W] ? {DATA_W{1'b1}} : sum_w[DATA_W-1:0];
  assign sub_res = (top_val > bus.mem_rdata) ? '0 : (bus.mem_rdata - top_val);
`else
  assign add_res = bus.mem_rdata + top_val;
  assign sub_res = bus.mem_rdata - top_val;
`endif

  assign alu_res = (cmd_q.op == OP_SUB) ? sub_res : add_res;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (in_op)
            OP_PUSH:                  if (!full_w) state_nxt = S_WR;
            OP_DUP:                   if (!empty_w && !full_w) state_nxt = S_WR;
            OP_POP:                   if (!depth_le1) state_nxt = S_RD;
            OP_ADD, OP_SUB, OP_SWAP:  if (!depth_le1) state_nxt = S_RD;
            OP_CLEAR:                 if (!empty_w) state_nxt = S_CLR;
            default:                  state_nxt = S_IDLE;
          endcase
        end
      end
      S_WR: begin
        mem_cs    = 1'b1;
        mem_we    = 1'b1;
        state_nxt = S_IDLE;
        if (cmd_q.op == OP_PUSH || cmd_q.op == OP_DUP) begin
          mem_addr  = free_addr;
          mem_wdata = (cmd_q.op == OP_PUSH) ? cmd_q.data : top_val;
        end else begin
          mem_addr  = nos_addr;
          mem_wdata = tmp_q;
        end
      end
      S_RD: begin
        mem_cs    = 1'b1;
        mem_addr  = (cmd_q.op == OP_POP) ? tos_addr : nos_addr;
        state_nxt = S_CAP;
      end
      S_CAP: begin
        if (cmd_q.op == OP_SWAP) begin
          mem_cs    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = nos_addr;
          mem_wdata = top_val;
          state_nxt = S_WR2;
        end else if (cmd_q.op == OP_POP) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_WR;
        end
      end
      S_WR2: begin
        mem_cs    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = tos_addr;
        mem_wdata = tmp_q;
        state_nxt = S_IDLE;
      end
      S_CLR: begin
        mem_cs    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = tos_addr;
        state_nxt = (depth == DEPTH_ONE) ? S_IDLE : S_CLR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q         <= '0;
      depth         <= '0;
      top_val       <= '0;
      tmp_q         <= '0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cmd_q <= '{op: in_op, data: bus.cmd_data};
            case (in_op)
              OP_PUSH: if (full_w) err_overflow <= 1'b1;
              OP_DUP: begin
                if (empty_w)     err_underflow <= 1'b1;
                else if (full_w) err_overflow  <= 1'b1;
              end
              OP_POP: begin
                if (empty_w) begin
                  err_underflow <= 1'b1;
                end else begin
                  depth <= depth - DEPTH_ONE;
                  if (depth == DEPTH_ONE) top_val <= '0;
                end
              end
              OP_ADD, OP_SUB, OP_SWAP: if (depth_le1) err_underflow <= 1'b1;
              OP_CLEAR: begin
                err_underflow <= 1'b0;
                err_overflow  <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        S_WR: begin
          top_val <= mem_wdata;
          if (cmd_q.op == OP_PUSH || cmd_q.op == OP_DUP) depth <= depth + DEPTH_ONE;
          else depth <= depth - DEPTH_ONE;
        end
        S_CAP: begin
          if (cmd_q.op == OP_POP)       top_val <= bus.mem_rdata;
          else if (cmd_q.op == OP_SWAP) tmp_q   <= bus.mem_rdata;
          else                          tmp_q   <= alu_res;
        end
        S_WR2: top_val <= tmp_q;
        S_CLR: begin
          depth <= depth - DEPTH_ONE;
          if (depth == DEPTH_ONE) top_val <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready     = (state == S_IDLE);
  assign bus.mem_cs        = mem_cs;
  assign bus.mem_we        = mem_we;
  assign bus.mem_addr      = mem_addr;
  assign bus.mem_wdata     = mem_wdata;
  assign bus.top_val       = top_val;
  assign bus.depth         = depth;
  assign bus.empty         = empty_w;
  assign bus.full          = full_w;
  assign bus.err_underflow = err_underflow;
  assign bus.err_overflow  = err_overflow;
endmodule

// File: tb/tb_stack_calc_core.sv
// Directed bench for stack_calc_core with D=8 and a behavioural sync RAM; honours STACK_CALC_SAT_EN.
module tb_stack_calc_core;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam logic [2:0] OP_NOP = 3'd0, OP_PUSH = 3'd1, OP_POP = 3'd2, OP_ADD = 3'd3,
                         OP_SUB = 3'd4, OP_DUP = 3'd5, OP_SWAP = 3'd6, OP_CLEAR = 3'd7;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cs_cnt = 0;
  int   cs0;
  int   lat;
  logic [DW-1:0] ram [0:7];
  logic [DW-1:0] exp_add, exp_sub;

  stack_calc_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  stack_calc_core #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_cs === 1'b1) begin
      cs_cnt++;
      if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_data  = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("ready_timeout", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_data  = '0;
  endtask

  // lat = cycles from the accepting edge until cmd_ready is seen again
  task automatic wait_ready();
    lat = 1;
    while (lat < 64) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) break;
      lat++;
    end
    if (lat >= 64) check("done_timeout", 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic cmd(input logic [2:0] op, input logic [DW-1:0] d);
    issue(op, d);
    wait_ready();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ram[i] = '0;
    bus.mem_rdata = '0;
`ifdef STACK_CALC_SAT_EN
    exp_add = 8'hFF;
    exp_sub = 8'hCF;
`else
    exp_add = 8'h10;
    exp_sub = 8'hE0;
`endif

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_depth", 32'(bus.depth), 32'd0);
    check("rst_top", 32'(bus.top_val), 32'h0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_errs", 32'({bus.err_underflow, bus.err_overflow}), 32'd0);
    check("rst_mem", 32'({bus.mem_cs, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'd0);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);

    // PUSH 5, PUSH 3, SUB
    cmd(OP_PUSH, 8'h05);
    check("push_lat", 32'(lat), 32'd2);
    cmd(OP_PUSH, 8'h03);
    cmd(OP_SUB, 8'h00);
    check("sub_lat", 32'(lat), 32'd4);
    check("sub_ram7", 32'(ram[7]), 32'h02);
    check("sub_top", 32'(bus.top_val), 32'h02);
    check("sub_depth", 32'(bus.depth), 32'd1);

    // ADD / SUB with carry and borrow
    do_reset();
    cmd(OP_PUSH, 8'hF0);
    cmd(OP_PUSH, 8'h20);
    cmd(OP_ADD, 8'h00);
    check("add_top", 32'(bus.top_val), 32'(exp_add));
    check("add_depth", 32'(bus.depth), 32'd1);
    cmd(OP_PUSH, 8'h30);
    cmd(OP_SUB, 8'h00);
    check("sub2_top", 32'(bus.top_val), 32'(exp_sub));
    check("sub2_ram7", 32'(ram[7]), 32'(exp_sub));
    check("sub2_depth", 32'(bus.depth), 32'd1);

    // Fill to D, then overflow
    do_reset();
    for (int i = 1; i <= 8; i++) cmd(OP_PUSH, 8'(i));
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_depth", 32'(bus.depth), 32'd8);
    check("fill_ram0", 32'(ram[0]), 32'h08);
    cs0 = cs_cnt;
    cmd(OP_PUSH, 8'h09);
    check("ovf_flag", 32'(bus.err_overflow), 32'd1);
    check("ovf_nocs", 32'(cs_cnt - cs0), 32'd0);
    check("ovf_depth", 32'(bus.depth), 32'd8);
    check("ovf_top", 32'(bus.top_val), 32'h08);
    check("ovf_lat", 32'(lat), 32'd1);

    // Underflow paths
    do_reset();
    cmd(OP_POP, 8'h00);
    check("unf_flag", 32'(bus.err_underflow), 32'd1);
    check("unf_top", 32'(bus.top_val), 32'h0);
    check("unf_depth", 32'(bus.depth), 32'd0);
    cmd(OP_PUSH, 8'h07);
    cs0 = cs_cnt;
    cmd(OP_ADD, 8'h00);
    check("unf_add_flag", 32'(bus.err_underflow), 32'd1);
    check("unf_add_depth", 32'(bus.depth), 32'd1);
    check("unf_add_top", 32'(bus.top_val), 32'h07);
    check("unf_add_nocs", 32'(cs_cnt - cs0), 32'd0);

    // SWAP, DUP, POP
    do_reset();
    cmd(OP_PUSH, 8'h01);
    cmd(OP_PUSH, 8'h02);
    cmd(OP_SWAP, 8'h00);
    check("swap_lat", 32'(lat), 32'd4);
    check("swap_ram7", 32'(ram[7]), 32'h02);
    check("swap_ram6", 32'(ram[6]), 32'h01);
    check("swap_top", 32'(bus.top_val), 32'h01);
    cmd(OP_DUP, 8'h00);
    check("dup_ram5", 32'(ram[5]), 32'h01);
    check("dup_depth", 32'(bus.depth), 32'd3);
    cmd(OP_POP, 8'h00);
    check("pop_lat", 32'(lat), 32'd3);
    check("pop_top", 32'(bus.top_val), 32'h01);
    check("pop_depth", 32'(bus.depth), 32'd2);
    cmd(OP_POP, 8'h00);
    check("pop2_top", 32'(bus.top_val), 32'h02);

    // CLEAR with depth 3 and both flags set
    do_reset();
    cmd(OP_POP, 8'h00);
    for (int i = 1; i <= 8; i++) cmd(OP_PUSH, 8'(i + 16));
    cmd(OP_PUSH, 8'h99);
    for (int i = 0; i < 5; i++) cmd(OP_POP, 8'h00);
    check("pre_clr_flags", 32'({bus.err_underflow, bus.err_overflow}), 32'h3);
    check("pre_clr_depth", 32'(bus.depth), 32'd3);
    issue(OP_CLEAR, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("clr_cs_we", 32'({bus.mem_cs, bus.mem_we, bus.cmd_ready}), 32'h6);
      check("clr_addr", 32'(bus.mem_addr), 32'(5 + i));
      check("clr_wdata", 32'(bus.mem_wdata), 32'h0);
      if (i == 0) check("clr_flags", 32'({bus.err_underflow, bus.err_overflow}), 32'h0);
    end
    @(negedge clk);
    check("clr_ready", 32'(bus.cmd_ready), 32'd1);
    check("clr_depth", 32'(bus.depth), 32'd0);
    check("clr_top", 32'(bus.top_val), 32'h0);
    check("clr_ram", 32'({ram[5], ram[6], ram[7]}), 32'h0);

    // Reset during the second CLR cycle
    cmd(OP_PUSH, 8'hA1);
    cmd(OP_PUSH, 8'hB2);
    cmd(OP_PUSH, 8'hC3);
    issue(OP_CLEAR, 8'h00);
    @(negedge clk);
    check("rclr_addr1", 32'(bus.mem_addr), 32'd5);
    @(negedge clk);
    check("rclr_addr2", 32'(bus.mem_addr), 32'd6);
    reset = 1'b1;
    @(negedge clk);
    check("rclr_cs", 32'(bus.mem_cs), 32'd0);
    check("rclr_depth", 32'(bus.depth), 32'd0);
    check("rclr_ready", 32'(bus.cmd_ready), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rclr_ram7", 32'(ram[7]), 32'hA1);
    check("rclr_idle_cs", 32'(bus.mem_cs), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
